// File: rtl/pg_sequencer.sv
// Product-gate step sequencer: arms on a command, waits for the next word-pair
// boundary, then drives the decoded product-gate controls for a counted number of pairs.
module pg_sequencer #(
  parameter int CNT_W = 7
) (
  input  logic             CLOCK,
  input  logic             rst_n,
  input  logic             T29,
  input  logic             CE,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             norm_hit,
  input  logic             abort,
  output logic             DS,
  output logic             S5,
  output logic             S6,
  output logic             SU,
  output logic             SV,
  output logic             SW,
  output logic             SX,
  output logic             CIR_3,
  output logic             CIR_4,
  output logic             last_pair,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] steps_left
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  typedef struct packed {
    logic ds;
    logic s5;
    logic s6;
    logic su;
    logic sv;
    logic sw;
    logic sx;
    logic cir3;
    logic cir4;
  } ctl_t;

  localparam logic [2:0] OP_NORM = 3'd5;

  state_t           state_q;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             abort_pend_q;
  ctl_t             ctl_q;
  logic             last_pair_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [CNT_W-1:0] steps_left_q;
  logic             pb;
  logic             run_stop;

  function automatic ctl_t decode_ctl(input logic [2:0] op);
    ctl_t c;
    c    = '0;
    c.ds = 1'b1;
    case (op)
      3'd0:    begin c.s5 = 1'b1; c.sx = 1'b1; c.cir4 = 1'b1; end
      3'd1:    begin c.s5 = 1'b1; c.sx = 1'b1; c.cir3 = 1'b1; end
      3'd2:    begin c.s6 = 1'b1; c.sw = 1'b1; end
      3'd3:    begin c.s6 = 1'b1; c.sv = 1'b1; end
      3'd4:    c.s6 = 1'b1;
      3'd5:    begin c.s6 = 1'b1; c.su = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign pb       = T29 & CE;
  assign cnt_d    = cnt_q - CNT_W'(1);
  // A mid-pair abort is remembered and honoured at the pair boundary so a pair is never cut short.
  assign run_stop = (cnt_q == CNT_W'(1)) || ((op_q == OP_NORM) && norm_hit) ||
                    abort || abort_pend_q;

  // NOTE: every register here, including the controls, takes the async reset so the
  // product gates drop the instant rst_n falls; all state updates use non-blocking <=.
  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= '0;
      cnt_q        <= '0;
      abort_pend_q <= 1'b0;
      ctl_q        <= '0;
      last_pair_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      steps_left_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            op_q         <= cmd_op;
            cnt_q        <= cmd_count;
            abort_pend_q <= 1'b0;
            if (cmd_op[2:1] == 2'b11) begin
              err_q <= 1'b1;
            end else if (cmd_count == '0) begin
              state_q      <= DONE;
              done_q       <= 1'b1;
              steps_left_q <= '0;
            end else begin
              state_q <= ARM;
              busy_q  <= 1'b1;
            end
          end
        end
        ARM: begin
          if (abort) begin
            state_q      <= DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            steps_left_q <= cnt_q;
          end else if (pb) begin
            state_q     <= RUN;
            ctl_q       <= decode_ctl(op_q);
            last_pair_q <= (cnt_q == CNT_W'(1));
          end
        end
        RUN: begin
          if (pb) begin
            cnt_q <= cnt_d;
            if (run_stop) begin
              state_q      <= DONE;
              ctl_q        <= '0;
              last_pair_q  <= 1'b0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              steps_left_q <= cnt_d;
            end else begin
              last_pair_q <= (cnt_q == CNT_W'(2));
            end
          end else if (abort) begin
            abort_pend_q <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign DS         = ctl_q.ds;
  assign S5         = ctl_q.s5;
  assign S6         = ctl_q.s6;
  assign SU         = ctl_q.su;
  assign SV         = ctl_q.sv;
  assign SW         = ctl_q.sw;
  assign SX         = ctl_q.sx;
  assign CIR_3      = ctl_q.cir3;
  assign CIR_4      = ctl_q.cir4;
  assign last_pair  = last_pair_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign steps_left = steps_left_q;

endmodule
